// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: walks the pipeline debug state (PC, register file,
// data memory) and hands one 32-bit word at a time to the TX bit-serial
// buffer, strobing o_tx_start only when the buffer reports empty.
// Optional feature macro: DUMP_HEADER_EN prepends a {16'hD0D0, count} word.
//
// Handshake: a word is offered by a single-cycle o_tx_start strobe while
// i_tx_buffer_empty is high. The buffer drops empty one cycle after it sees
// the strobe, so empty is sampled again only after the intervening FETCH
// cycle. That guarantees exactly one strobe per word.
module debug_dump_sequencer #(
    parameter int INSTRUCT_MEM_WIDTH = 32,
    parameter int NUM_REGS           = 32,
    parameter int REG_ADDR_WIDTH     = 5,
    parameter int NUM_MEM_WORDS      = 16,
    parameter int MEM_ADDR_WIDTH     = 5
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_dump_start,
    input  logic                          i_tx_buffer_empty,
    input  logic [INSTRUCT_MEM_WIDTH-1:0] i_pc,
    input  logic [INSTRUCT_MEM_WIDTH-1:0] i_reg_data,
    input  logic [INSTRUCT_MEM_WIDTH-1:0] i_mem_data,
    output logic [REG_ADDR_WIDTH-1:0]     o_reg_addr,
    output logic [MEM_ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [INSTRUCT_MEM_WIDTH-1:0] o_pipeline_info,
    output logic                          o_tx_start,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [15:0]                   o_words_sent,
    output logic [2:0]                    o_dbg_state
);

`ifdef DUMP_HEADER_EN
    localparam int HDR     = 1;
    localparam int PAYLOAD = NUM_REGS + NUM_MEM_WORDS + 1;
`else
    localparam int HDR     = 0;
`endif
    // Index of the final word of the frame.
    localparam int LAST = HDR + NUM_REGS + NUM_MEM_WORDS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SEND   = 3'd2,
        S_PULSE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                          state_q, state_d;
    logic [15:0]                     k_q, k_d;
    logic [INSTRUCT_MEM_WIDTH-1:0]   info_q, info_d;
    logic                            tx_q, tx_d;
    logic                            done_q, done_d;
    logic                            busy_q, busy_d;
    logic [15:0]                     words_q, words_d;
    logic [REG_ADDR_WIDTH-1:0]       reg_addr_q, reg_addr_d;
    logic [MEM_ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
    logic [INSTRUCT_MEM_WIDTH-1:0]   sel_word;
    logic                            in_reg, in_mem;

    // Word selected by the current frame index k.
    always_comb begin
        sel_word = i_mem_data;
`ifdef DUMP_HEADER_EN
        if (k_q == 16'd0)
            sel_word = {16'hD0D0, 16'(PAYLOAD)};
        else
`endif
        if (k_q == 16'(HDR))
            sel_word = i_pc;
        else if (k_q <= 16'(HDR + NUM_REGS))
            sel_word = i_reg_data;
    end

    // Next-state and registered-output logic of the dump FSM.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        info_d  = info_q;
        tx_d    = 1'b0;
        done_d  = 1'b0;
        words_d = words_q;
        case (state_q)
            S_IDLE: begin
                if (i_dump_start) begin
                    state_d = S_FETCH;
                    k_d     = 16'd0;
                    words_d = 16'd0;
                end
            end
            S_FETCH: begin
                info_d  = sel_word;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (i_tx_buffer_empty) begin
                    tx_d    = 1'b1;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                words_d = words_q + 16'd1;
                if (k_q == 16'(LAST)) begin
                    state_d = S_FINISH;
                end else begin
                    k_d     = k_q + 16'd1;
                    state_d = S_FETCH;
                end
            end
            S_FINISH: begin
                if (i_tx_buffer_empty) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Read addresses follow the next index so read data is settled at FETCH.
    always_comb begin
        in_reg     = (k_d >= 16'(HDR + 1)) && (k_d <= 16'(HDR + NUM_REGS));
        in_mem     = (k_d > 16'(HDR + NUM_REGS)) && (k_d <= 16'(LAST));
        reg_addr_d = in_reg ? REG_ADDR_WIDTH'(k_d - 16'(HDR + 1)) : '0;
        mem_addr_d = in_mem ? MEM_ADDR_WIDTH'(k_d - 16'(HDR + NUM_REGS + 1)) : '0;
    end

    // State and output registers; async reset clears everything to IDLE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            info_q     <= '0;
            tx_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            words_q    <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            info_q     <= info_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            words_q    <= words_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign o_reg_addr      = reg_addr_q;
    assign o_mem_addr      = mem_addr_q;
    assign o_pipeline_info = info_q;
    assign o_tx_start      = tx_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_words_sent    = words_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer (NUM_REGS=4, NUM_MEM_WORDS=2) with
// a TX buffer model that stays busy 32 cycles after each strobe.
module tb_debug_dump_sequencer;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_dump_start = 1'b0;
    logic        i_tx_buffer_empty;
    logic [31:0] i_pc = 32'h40;
    logic [31:0] i_reg_data;
    logic [31:0] i_mem_data;
    logic [4:0]  o_reg_addr;
    logic [4:0]  o_mem_addr;
    logic [31:0] o_pipeline_info;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_words_sent;
    logic [2:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    logic [31:0] regs [0:31];
    logic [31:0] mems [0:31];
    logic        model_empty = 1'b1;
    logic        hold_low = 1'b0;
    int          drain = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    int          consec_cnt = 0;
    logic        prev_tx = 1'b0;

    localparam int NWORDS_BASE = 7;
`ifdef DUMP_HEADER_EN
    localparam int NWORDS = NWORDS_BASE + 1;
`else
    localparam int NWORDS = NWORDS_BASE;
`endif

    debug_dump_sequencer #(
        .INSTRUCT_MEM_WIDTH(32),
        .NUM_REGS(4),
        .REG_ADDR_WIDTH(5),
        .NUM_MEM_WORDS(2),
        .MEM_ADDR_WIDTH(5)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_dump_start(i_dump_start),
        .i_tx_buffer_empty(i_tx_buffer_empty),
        .i_pc(i_pc),
        .i_reg_data(i_reg_data),
        .i_mem_data(i_mem_data),
        .o_reg_addr(o_reg_addr),
        .o_mem_addr(o_mem_addr),
        .o_pipeline_info(o_pipeline_info),
        .o_tx_start(o_tx_start),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_words_sent(o_words_sent),
        .o_dbg_state(o_dbg_state)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    // Combinational register file / data memory read ports.
    assign i_reg_data = regs[o_reg_addr];
    assign i_mem_data = mems[o_mem_addr];
    assign i_tx_buffer_empty = model_empty & ~hold_low;

    // TX buffer model: busy for 32 cycles after each strobe.
    always @(posedge i_clk) begin
        if (o_tx_start) begin
            model_empty <= 1'b0;
            drain <= 32;
        end else if (drain != 0) begin
            drain <= drain - 1;
            if (drain == 1) model_empty <= 1'b1;
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (o_tx_start) begin
            got_q.push_back(o_pipeline_info);
            strobe_cnt++;
            if (prev_tx) consec_cnt++;
        end
        if (o_done) done_cnt++;
        prev_tx = o_tx_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        strobe_cnt = 0;
        done_cnt = 0;
        consec_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_dump_start = 1'b1;
        @(posedge i_clk);
        #1 i_dump_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk({tag, "_words_sent"}, {16'd0, o_words_sent}, NWORDS);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_no_consec"}, consec_cnt, 0);
        chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'hDEAD_0000 + i;
            mems[i] = 32'hBEEF_0000 + i;
        end
        regs[0] = 32'h11; regs[1] = 32'h22; regs[2] = 32'h33; regs[3] = 32'h44;
        mems[0] = 32'hA0; mems[1] = 32'hB0;
`ifdef DUMP_HEADER_EN
        exp_q.push_back(32'hD0D0_0007);
`endif
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22);
        exp_q.push_back(32'h33); exp_q.push_back(32'h44);
        exp_q.push_back(32'hA0); exp_q.push_back(32'hB0);

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_tx", {31'd0, o_tx_start}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_done", {31'd0, o_done}, 0);
        chk("rst_words", {16'd0, o_words_sent}, 0);
        chk("rst_info", o_pipeline_info, 0);
        chk("rst_addr", {22'd0, o_reg_addr, o_mem_addr}, 0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Latency with empty high, then full frame.
        clear_mon();
        pulse_start();
        chk("lat_n_busy", {31'd0, o_busy}, 1);
        chk("lat_n_tx", {31'd0, o_tx_start}, 0);
        @(posedge i_clk); #1;
        chk("lat_n1_tx", {31'd0, o_tx_start}, 0);
        chk("lat_n1_info", o_pipeline_info, exp_q[0]);
        @(posedge i_clk); #1;
        chk("lat_n2_tx", {31'd0, o_tx_start}, 1);
        @(posedge i_clk); #1;
        chk("lat_n3_tx", {31'd0, o_tx_start}, 0);
        chk("lat_n3_words", {16'd0, o_words_sent}, 1);
        wait_done("frame1_done");
        check_frame("frame1");

        // Start re-pulsed mid-dump is ignored.
        clear_mon();
        pulse_start();
        repeat (50) @(posedge i_clk);
        pulse_start();
        repeat (60) @(posedge i_clk);
        pulse_start();
        wait_done("repulse_done");
        check_frame("repulse");

        // Empty stuck low in SEND, then released.
        clear_mon();
        hold_low = 1'b1;
        pulse_start();
        repeat (100) @(posedge i_clk);
        #1;
        chk("stuck_no_strobe", strobe_cnt, 0);
        chk("stuck_busy", {31'd0, o_busy}, 1);
        chk("stuck_state", {29'd0, o_dbg_state}, 2);
        @(negedge i_clk);
        hold_low = 1'b0;
        @(posedge i_clk); #1;
        chk("release_tx", {31'd0, o_tx_start}, 1);
        wait_done("stuck_done");
        check_frame("stuck");

        // Reset mid-dump, start held during reset, then clean restart.
        clear_mon();
        pulse_start();
        repeat (40) @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        i_dump_start = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, o_tx_start}, 0);
        chk("midrst_busy", {31'd0, o_busy}, 0);
        chk("midrst_words", {16'd0, o_words_sent}, 0);
        chk("midrst_info", o_pipeline_info, 0);
        chk("midrst_state", {29'd0, o_dbg_state}, 0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_wins_busy", {31'd0, o_busy}, 0);
        @(negedge i_clk);
        i_dump_start = 1'b0;
        i_reset = 1'b1;
        repeat (40) @(posedge i_clk);
        clear_mon();
        pulse_start();
        wait_done("restart_done");
        check_frame("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
